// File: rtl/nmr_sched_pkg.sv
// Shared types for the timestamp event scheduler: FSM states and the default queued entry layout.
package nmr_sched_pkg;

   localparam int SCHED_TS_W  = 64;
   localparam int SCHED_OUT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [SCHED_TS_W-1:0]  fire_time;
      logic [SCHED_OUT_W-1:0] word;
   } sched_entry_t;

endpackage

// File: rtl/sched_fifo.sv
// DEPTH-entry queue with wrap-bit pointers; head is read combinationally, push/pop/flush take effect at the edge.
// The caller must not push when full; flush empties the queue and wins over push and pop.
module sched_fifo
   import nmr_sched_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = sched_entry_t
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  T                       din,
   input  logic                   pop,
   input  logic                   flush,
   output T                       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   T            mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   // Equal index with differing wrap bit means the writer has lapped the reader.
   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ns_event_scheduler.sv
// Fires queued words onto the pulse bus 2 edges after time_elaps reaches their fire time; wr_ready drops when full.
// Defining SCHED_LATE_CHECK_EN builds the sticky late_err check; otherwise late_err is tied low.
module ns_event_scheduler
   import nmr_sched_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int OUT_W    = 16,
   parameter int TS_W     = SCHED_TS_W,
   parameter int LATE_TOL = 10
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [TS_W-1:0]            time_elaps,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [TS_W-1:0]            wr_time,
   input  logic [OUT_W-1:0]           wr_word,
   input  logic                       arm,
   input  logic                       abort,
   output logic [OUT_W-1:0]           out_word,
   output logic                       out_strobe,
   output logic                       busy,
   output logic                       done,
   output logic                       late_err,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [TS_W-1:0]  fire_time;
      logic [OUT_W-1:0] word;
   } entry_t;

   sched_state_e     state_q, state_d;
   logic             due_q, due_d;
   logic [OUT_W-1:0] out_word_q, out_word_d;
   logic             out_strobe_q, out_strobe_d;
   logic             push, pop, full, empty;
   logic [CW-1:0]    fifo_count;
   entry_t           wr_entry, head;

   assign wr_entry = '{fire_time: wr_time, word: wr_word};
   assign push     = wr_valid && !full && !abort;

   sched_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (wr_entry),
      .pop     (pop),
      .flush   (abort),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   // due_q stays low on a fire edge so a freshly exposed head is compared a cycle later.
   always_comb begin
      state_d      = state_q;
      due_d        = 1'b0;
      out_word_d   = out_word_q;
      out_strobe_d = 1'b0;
      pop          = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (due_q) begin
                  out_word_d   = head.word;
                  out_strobe_d = 1'b1;
                  pop          = 1'b1;
                  if ((fifo_count == CW'(1)) && !push) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  due_d = !empty && (time_elaps >= head.fire_time);
               end
            end
            default: begin
               if (arm) begin
                  state_d = empty ? ST_DONE : ST_RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         due_q        <= 1'b0;
         out_word_q   <= '0;
         out_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         due_q        <= due_d;
         out_word_q   <= out_word_d;
         out_strobe_q <= out_strobe_d;
      end
   end

`ifdef SCHED_LATE_CHECK_EN
   logic            late_q, late_d, arm_ok;
   logic [TS_W-1:0] lateness;

   always_comb begin
      arm_ok   = arm && !abort && (state_q != ST_RUN);
      lateness = time_elaps - head.fire_time;
      late_d   = late_q;
      if (arm_ok) begin
         late_d = 1'b0;
      end
      if (pop && (lateness > TS_W'(LATE_TOL))) begin
         late_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         late_q <= 1'b0;
      end else begin
         late_q <= late_d;
      end
   end

   assign late_err = late_q;
`else
   assign late_err = 1'b0;
`endif

   assign wr_ready   = !full;
   assign out_word   = out_word_q;
   assign out_strobe = out_strobe_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign count      = fifo_count;

endmodule

// File: tb/tb_ns_event_scheduler.sv
// Bench for ns_event_scheduler: queue-level reference model checked every cycle, plus directed literal checks.
module tb_ns_event_scheduler;

   localparam int DEPTH    = 8;
   localparam int OUT_W    = 16;
   localparam int TS_W     = 64;
   localparam int LATE_TOL = 10;
   localparam int CW       = $clog2(DEPTH + 1);
`ifdef SCHED_LATE_CHECK_EN
   localparam bit LATE_ON = 1'b1;
`else
   localparam bit LATE_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [TS_W-1:0]  time_elaps = '0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [TS_W-1:0]  wr_time = '0;
   logic [OUT_W-1:0] wr_word = '0;
   logic             arm = 1'b0;
   logic             abort = 1'b0;
   logic [OUT_W-1:0] out_word;
   logic             out_strobe;
   logic             busy;
   logic             done;
   logic             late_err;
   logic [CW-1:0]    count;

   ns_event_scheduler #(
      .DEPTH    (DEPTH),
      .OUT_W    (OUT_W),
      .TS_W     (TS_W),
      .LATE_TOL (LATE_TOL)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .time_elaps (time_elaps),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_time    (wr_time),
      .wr_word    (wr_word),
      .arm        (arm),
      .abort      (abort),
      .out_word   (out_word),
      .out_strobe (out_strobe),
      .busy       (busy),
      .done       (done),
      .late_err   (late_err),
      .count      (count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   logic [TS_W-1:0] step = 64'd5;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the queue of pending entries and the scheduler mode.
   typedef struct {
      logic [TS_W-1:0]  t;
      logic [OUT_W-1:0] w;
   } ent_t;
   typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;

   ent_t             mq[$];
   mst_t             m_st = M_IDLE;
   logic [OUT_W-1:0] m_word = '0;
   logic             m_strobe = 1'b0;
   logic             m_late = 1'b0;
   int               edge_n = 0;
   int               head_since = 0;
   logic [TS_W-1:0]  prev_time = '0;

   logic [OUT_W-1:0] s_word[$];
   int               s_edge[$];
   logic [TS_W-1:0]  s_time[$];

   // Inputs change only at negedge+1, so at negedge they still hold what the last rising edge sampled.
   // A head may fire at edge n once it has been the head in RUN for an earlier edge that saw time >= its fire time.
   initial begin : model_cmp
      int   sz0;
      bit   fire;
      ent_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mq.delete();
            m_st     = M_IDLE;
            m_word   = '0;
            m_strobe = 1'b0;
            m_late   = 1'b0;
         end else begin
            edge_n++;
            sz0      = mq.size();
            m_strobe = 1'b0;
            if (abort) begin
               mq.delete();
               m_st = M_IDLE;
            end else begin
               fire = (m_st == M_RUN) && (sz0 > 0) && (edge_n > head_since + 1) && (prev_time >= mq[0].t);
               if (fire) begin
                  m_word   = mq[0].w;
                  m_strobe = 1'b1;
                  if (LATE_ON && ((time_elaps - mq[0].t) > 64'(LATE_TOL))) m_late = 1'b1;
                  void'(mq.pop_front());
                  head_since = edge_n;
               end
               if (wr_valid && (sz0 < DEPTH)) begin
                  e.t = wr_time;
                  e.w = wr_word;
                  mq.push_back(e);
               end
               if (fire && (mq.size() == 0)) begin
                  m_st = M_DONE;
               end else if ((m_st != M_RUN) && arm) begin
                  m_late = 1'b0;
                  if (sz0 == 0) begin
                     m_st = M_DONE;
                  end else begin
                     m_st       = M_RUN;
                     head_since = edge_n;
                  end
               end
            end
            prev_time = time_elaps;
         end
         if (chk_en) begin
            chk("out_word",   64'(out_word),   64'(m_word));
            chk("out_strobe", 64'(out_strobe), 64'(m_strobe));
            chk("busy",       64'(busy),       64'(m_st == M_RUN));
            chk("done",       64'(done),       64'(m_st == M_DONE));
            chk("late_err",   64'(late_err),   64'(m_late));
            chk("count",      64'(count),      64'(mq.size()));
            chk("wr_ready",   64'(wr_ready),   64'(mq.size() < DEPTH));
            if (out_strobe === 1'b1) begin
               s_word.push_back(out_word);
               s_edge.push_back(edge_n);
               s_time.push_back(time_elaps);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      time_elaps = time_elaps + step;
      wr_valid   = 1'b0;
      arm        = 1'b0;
      abort      = 1'b0;
   endtask

   task automatic push_entry(input logic [TS_W-1:0] t, input logic [OUT_W-1:0] w);
      wr_valid = 1'b1;
      wr_time  = t;
      wr_word  = w;
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      arm      = 1'b0;
      abort    = 1'b0;
      tick();
      tick();
      time_elaps = '0;
      reset_n    = 1'b1;
      s_word.delete();
      s_edge.delete();
      s_time.delete();
   endtask

   task automatic wait_strobes(input int n, input int budget, input string nm);
      int k;
      k = 0;
      while ((s_word.size() < n) && (k < budget)) begin
         tick();
         k++;
      end
      chk({nm, "_strobe_seen"}, 64'(s_word.size() >= n), 64'd1);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int arm_edge;
      logic [TS_W-1:0] base;
      #3;
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_out_word",   64'(out_word),   64'd0);
      chk("rst_out_strobe", 64'(out_strobe), 64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_done",       64'(done),       64'd0);
      chk("rst_count",      64'(count),      64'd0);
      chk("rst_wr_ready",   64'(wr_ready),   64'd1);
      time_elaps = '0;
      reset_n    = 1'b1;
      chk_en     = 1'b1;

      // Basic two-entry sequence at +5 ns per clock.
      step = 64'd5;
      push_entry(64'd100, 16'h00A5);
      push_entry(64'd200, 16'h005A);
      arm = 1'b1;
      tick();
      wait_strobes(2, 100, "basic");
      if (s_word.size() >= 2) begin
         chk("basic_word0", 64'(s_word[0]), 64'h00A5);
         chk("basic_time0", s_time[0],      64'd105);
         chk("basic_word1", 64'(s_word[1]), 64'h005A);
         chk("basic_time1", s_time[1],      64'd205);
      end
      chk("basic_done",  64'(done),  64'd1);
      chk("basic_count", 64'(count), 64'd0);

      // Fill to DEPTH, then offer one more.
      do_reset();
      for (int i = 0; i < DEPTH; i++) push_entry(64'd5000 + 64'(i), 16'(i));
      chk("full_count",    64'(count),    64'd8);
      chk("full_wr_ready", 64'(wr_ready), 64'd0);
      push_entry(64'd6000, 16'hFFFF);
      chk("full_9th_dropped", 64'(count), 64'd8);

      // Equal timestamps fire in write order, two cycles apart.
      do_reset();
      push_entry(64'd300, 16'h1111);
      push_entry(64'd300, 16'h2222);
      arm = 1'b1;
      tick();
      wait_strobes(2, 200, "equal");
      if (s_word.size() >= 2) begin
         chk("equal_word0",   64'(s_word[0]),             64'h1111);
         chk("equal_word1",   64'(s_word[1]),             64'h2222);
         chk("equal_spacing", 64'(s_edge[1] - s_edge[0]), 64'd2);
         chk("equal_time0",   s_time[0],                  64'd305);
      end

      // A past entry fires two edges after RUN entry; late_err is sticky until the next arm.
      do_reset();
      step       = 64'd0;
      time_elaps = 64'd1000;
      push_entry(64'd50, 16'h0BAD);
      arm = 1'b1;
      tick();
      arm_edge = edge_n;
      wait_strobes(1, 10, "late");
      if (s_word.size() >= 1) chk("late_fire_edge", 64'(s_edge[0] - arm_edge), 64'd2);
      tick();
      tick();
      chk("late_err_sticky", 64'(late_err), 64'(LATE_ON));
      arm = 1'b1;
      tick();
      chk("late_err_cleared_by_arm", 64'(late_err), 64'd0);

      // Abort while RUN with three entries pending.
      do_reset();
      step = 64'd5;
      push_entry(64'd100, 16'h0001);
      push_entry(64'd200, 16'h0002);
      push_entry(64'd300, 16'h0003);
      push_entry(64'd400, 16'h0004);
      arm = 1'b1;
      tick();
      wait_strobes(1, 100, "abort");
      abort = 1'b1;
      tick();
      chk("abort_count",    64'(count),    64'd0);
      chk("abort_busy",     64'(busy),     64'd0);
      chk("abort_done",     64'(done),     64'd0);
      chk("abort_out_word", 64'(out_word), 64'h0001);
      repeat (100) tick();
      chk("abort_no_more_strobes", 64'(s_word.size()), 64'd1);

      // Asynchronous reset in the middle of RUN.
      do_reset();
      push_entry(64'd100, 16'h0007);
      push_entry(64'd500, 16'h0008);
      arm = 1'b1;
      tick();
      wait_strobes(1, 100, "midrst");
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_word",   64'(out_word),   64'd0);
      chk("midrst_out_strobe", 64'(out_strobe), 64'd0);
      chk("midrst_busy",       64'(busy),       64'd0);
      chk("midrst_done",       64'(done),       64'd0);
      chk("midrst_late_err",   64'(late_err),   64'd0);
      chk("midrst_count",      64'(count),      64'd0);
      chk("midrst_wr_ready",   64'(wr_ready),   64'd1);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (120) tick();
      chk("midrst_no_strobe_after", 64'(s_word.size()), 64'd1);

      // Randomized traffic; every cycle is checked against the model.
      for (int r = 0; r < 15; r++) begin
         do_reset();
         base       = ((r % 4) == 0) ? 64'h8000_0000_0000_0000 : 64'd0;
         time_elaps = base + 64'($urandom_range(0, 400));
         step       = 64'($urandom_range(0, 6));
         for (int c = 0; c < 260; c++) begin
            if ((c < 12) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0)) begin
               wr_valid = 1'b1;
               wr_time  = ((time_elaps > base + 64'd100) ? (time_elaps - 64'd100) : base)
                          + 64'($urandom_range(0, 400));
               wr_word  = 16'($urandom);
            end
            arm   = (c == 12) || ($urandom_range(0, 24) == 0);
            abort = ($urandom_range(0, 69) == 0);
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ns_event_scheduler.md
# ns_event_scheduler

Timestamp-driven output sequencer: the consumer of the free-running `ns_timer` count. Software-side logic loads (fire time, output word) pairs into an internal queue. Once armed, the block compares the head entry against `time_elaps` and drives each word onto the pulse-control bus when its time is reached. It sits between the host register interface and the RF/gate pulse outputs of the NMR spectrometer.

## Interface
- `DEPTH`, 8: queue entries (power of two, ≥2)
- `OUT_W`, 16: output word width
- `TS_W`, 64: timestamp width; must match `time_elaps`
- `LATE_TOL`, 10: allowed firing overshoot in ns before the late flag sets
- `clk` in 1: single system clock
- `reset_n` in 1: asynchronous, active-low reset
- `time_elaps` in TS_W: current ns count from `ns_timer`, monotonic non-decreasing
- `wr_valid` in 1: entry write request
- `wr_ready` out 1: queue can accept an entry
- `wr_time` in TS_W: entry fire time (ns)
- `wr_word` in OUT_W: entry output word
- `arm` in 1: single-cycle start pulse
- `abort` in 1: single-cycle flush and stop
- `out_word` out OUT_W: registered pulse-control word
- `out_strobe` out 1: one-cycle pulse when `out_word` updates
- `busy` out 1: state is RUN
- `done` out 1: state is DONE
- `late_err` out 1: sticky; an entry fired more than LATE_TOL late
- `count` out $clog2(DEPTH+1): entries queued

## Operation
- **Write:**
  - An entry is accepted on a rising edge with `wr_valid && wr_ready`.
  - `wr_ready = !full`, computed from registered state. A pop in the same cycle does not free space for a write.
  - Writes are allowed in every state.
- **States:** IDLE, RUN, DONE.
  - IDLE/DONE on `arm`: go to RUN if the queue is non-empty, otherwise go to DONE.
  - RUN: when the head is due, fire it:
    - `out_word` ← head word, `out_strobe` = 1, pop the head.
    - If the queue becomes empty and no write is accepted in the same cycle, go to DONE.
  - `arm` while in RUN is ignored.
  - DONE holds `done` = 1 until `arm` or `abort`.
- **Due:** `time_elaps >= head_time`, unsigned TS_W compare, registered into `due_q`.
  - `due_q` is cleared on every pop, which prevents a double fire.
  - The next head's compare starts the following cycle.
- **Ordering:** entries fire strictly in queue order.
  - An out-of-order (already past) entry fires as soon as it reaches the head.
- **Abort:** from any state, go to IDLE at the next edge.
  - Flush the queue (`count` = 0), no strobe.
  - `out_word` retains its last value.
  - A write presented in the abort cycle is dropped.
  - `abort` has priority over `arm`, write and fire.
- **Reset values:**
  - State IDLE; `out_word` 0; `out_strobe`, `busy`, `done`, `late_err`, `count` all 0; `wr_ready` 1.
  - Queue pointers are 0.

## Timing
- **Latency:**
  - `time_elaps` ≥ T sampled at edge k sets `due_q` at edge k.
  - `out_word`/`out_strobe` update at edge k+1.
  - So the output changes 2 edges after the qualifying `time_elaps` value is presented.
- **Spacing:** minimum 2 cycles between consecutive strobes, including equal timestamps.
- **Arm to first compare:** RUN is entered at the edge after `arm`; the first possible strobe is 2 edges later.
- `count` reflects a write or pop at the same edge as the handshake or fire.
  - A simultaneous write and pop leaves `count` unchanged.
- Full/empty use DEPTH+1 state pointers (extra wrap bit). No entry is ever lost or duplicated.

## Configuration
- **`SCHED_LATE_CHECK_EN` defined:**
  - At fire, compute `time_elaps - head_time` (TS_W, unsigned).
  - If it is > LATE_TOL, set `late_err`.
  - `late_err` clears only on reset or `arm`.
- **Undefined:** `late_err` is tied to 0 and no subtractor is built.

## Structure
- Package `nmr_sched_pkg`:
  - state enum (IDLE, RUN, DONE)
  - `TS_W` default
  - entry struct {time, word}
- Sub-module `sched_fifo`: synchronous DEPTH-entry queue with push/pop/full/empty/count.
  - Same clock and `reset_n`.
  - Head is visible combinationally.
- Top level contains the compare register, FSM, output registers and late check.

## Test plan
- **Reset:** assert `reset_n`=0 mid-RUN → all outputs take their reset values asynchronously; no strobe after release.
- **Basic sequence:**
  - Stimulus: write (100, 0x00A5), (200, 0x005A); arm at `time_elaps`=0; `time_elaps` +5 per clock.
  - Response: strobe with `out_word`=0x00A5 two edges after `time_elaps`=100; strobe with 0x005A two edges after 200; then `done`=1, `count`=0.
- **Full:** write 8 entries with DEPTH=8 → `wr_ready`=0 and `count`=8; a 9th `wr_valid` is not accepted.
- **Equal times:** two entries at 300 → two strobes exactly 2 cycles apart, in write order.
- **Late:**
  - Stimulus: with LATE_TOL=10, arm with entry 50 while `time_elaps`=1000.
  - Response: fires 2 edges after RUN entry; `late_err`=1 (sticky) with `SCHED_LATE_CHECK_EN`, 0 without.
- **Abort:**
  - Stimulus: abort in RUN with 3 entries pending.
  - Response: next edge `count`=0, `busy`=0, `done`=0, `out_word` unchanged; no strobes while `time_elaps` passes the flushed times.
